// File: rtl/iot_extreme_filter_if.sv
// Bundles the control, beat-stream and result signals of iot_extreme_filter.
// The iot_idx signal exists only when IOTF_INDEX_EN is defined.
interface iot_extreme_filter_if #(
    parameter int DATA_W  = 128,
    parameter int IN_W    = 8,
    parameter int ROUND_N = 8
);
    logic              start;
    logic              mode;
    logic [7:0]        rounds;
    logic              in_en;
    logic [IN_W-1:0]   iot_in;
    logic              busy;
    logic              valid;
    logic [DATA_W-1:0] iot_out;
`ifdef IOTF_INDEX_EN
    logic [$clog2(ROUND_N)-1:0] iot_idx;
`endif

    modport master (
        output start, mode, rounds, in_en, iot_in,
`ifdef IOTF_INDEX_EN
        input  iot_idx,
`endif
        input  busy, valid, iot_out
    );

    modport slave (
        input  start, mode, rounds, in_en, iot_in,
`ifdef IOTF_INDEX_EN
        output iot_idx,
`endif
        output busy, valid, iot_out
    );
endinterface

// File: rtl/iot_extreme_filter.sv
// Assembles IN_W-bit beats into DATA_W-bit words and reports the min/max word of each
// ROUND_N-word round. Optional macro IOTF_INDEX_EN adds the winning word index output.
module iot_extreme_filter #(
    parameter int DATA_W  = 128,
    parameter int IN_W    = 8,
    parameter int ROUND_N = 8
) (
    input logic                 clk,
    input logic                 rst,
    iot_extreme_filter_if.slave bus
);
    localparam int BEATS = DATA_W / IN_W;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WCW   = $clog2(ROUND_N);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(ROUND_N - 1);

    typedef enum logic [1:0] {IDLE, FIRST, ACCUM} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] sr, acc, word;
    logic [BCW-1:0]    beat_cnt;
    logic [WCW-1:0]    word_cnt;
    logic [7:0]        round_cnt, rounds_lat;
    logic              mode_lat;
    logic              go, accept, last_beat, end_round, better;
`ifdef IOTF_INDEX_EN
    logic [WCW-1:0]    acc_idx;
`endif

    // The assembled word includes the beat arriving this cycle, so the compare needs no extra cycle.
    assign word      = (sr << IN_W) | DATA_W'(bus.iot_in);
    assign go        = bus.start && (bus.rounds != 8'd0);
    assign accept    = bus.in_en && (state != IDLE);
    assign last_beat = accept && (beat_cnt == BEAT_LAST);
    assign end_round = last_beat && (state == ACCUM) && (word_cnt == WORD_LAST);
    assign better    = mode_lat ? (word > acc) : (word < acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = FIRST;
            FIRST:   if (last_beat) state_nxt = ACCUM;
            ACCUM: begin
                if (end_round)
                    state_nxt = (round_cnt + 8'd1 == rounds_lat) ? IDLE : FIRST;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr          <= '0;
            acc         <= '0;
            beat_cnt    <= '0;
            word_cnt    <= '0;
            round_cnt   <= '0;
            rounds_lat  <= '0;
            mode_lat    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.valid   <= 1'b0;
            bus.iot_out <= '0;
`ifdef IOTF_INDEX_EN
            acc_idx     <= '0;
            bus.iot_idx <= '0;
`endif
        end else begin
            bus.valid <= end_round;
            bus.busy  <= (state_nxt != IDLE);

            if (state == IDLE && go) begin
                mode_lat   <= bus.mode;
                rounds_lat <= bus.rounds;
                beat_cnt   <= '0;
                word_cnt   <= '0;
                round_cnt  <= '0;
            end

            if (accept) begin
                sr       <= word;
                beat_cnt <= last_beat ? '0 : beat_cnt + BCW'(1);
            end

            // Strict compares keep the earliest word on ties.
            if (last_beat) begin
                word_cnt <= (word_cnt == WORD_LAST) ? '0 : word_cnt + WCW'(1);
                if (state == FIRST || better) begin
                    acc <= word;
`ifdef IOTF_INDEX_EN
                    acc_idx <= word_cnt;
`endif
                end
            end

            if (end_round) begin
                bus.iot_out <= better ? word : acc;
`ifdef IOTF_INDEX_EN
                bus.iot_idx <= better ? word_cnt : acc_idx;
`endif
                round_cnt   <= round_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_iot_extreme_filter.sv
// Randomized self-checking bench for iot_extreme_filter against a two-pass extreme/index model.
// Define IOTF_INDEX_EN to also check the winning index.
module tb_iot_extreme_filter;
    localparam int DATA_W  = 128;
    localparam int IN_W    = 8;
    localparam int ROUND_N = 8;
    localparam int BEATS   = DATA_W / IN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    iot_extreme_filter_if #(.DATA_W(DATA_W), .IN_W(IN_W), .ROUND_N(ROUND_N)) bus ();

    iot_extreme_filter #(.DATA_W(DATA_W), .IN_W(IN_W), .ROUND_N(ROUND_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DATA_W-1:0] words [ROUND_N];
    logic [DATA_W-1:0] q_val [$];
    int                q_idx [$];
    int                q_cyc [$];
    bit                q_busy [$];

    always @(negedge clk) begin
        if (bus.valid) begin
            q_val.push_back(bus.iot_out);
`ifdef IOTF_INDEX_EN
            q_idx.push_back(int'(bus.iot_idx));
`else
            q_idx.push_back(0);
`endif
            q_cyc.push_back(cyc);
            q_busy.push_back(bus.busy);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_val.delete();
        q_idx.delete();
        q_cyc.delete();
        q_busy.delete();
    endtask

    // Extreme value first, then the earliest word equal to it.
    task automatic ref_model(input bit m, output logic [DATA_W-1:0] v, output int ix);
        v = words[0];
        for (int i = 1; i < ROUND_N; i++)
            if ((m && words[i] > v) || (!m && words[i] < v)) v = words[i];
        ix = -1;
        for (int i = 0; i < ROUND_N; i++)
            if (ix < 0 && words[i] == v) ix = i;
    endtask

    task automatic load8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        words[0] = DATA_W'(a0); words[1] = DATA_W'(a1);
        words[2] = DATA_W'(a2); words[3] = DATA_W'(a3);
        words[4] = DATA_W'(a4); words[5] = DATA_W'(a5);
        words[6] = DATA_W'(a6); words[7] = DATA_W'(a7);
    endtask

    task automatic load_rand(input bit high);
        for (int i = 0; i < ROUND_N; i++) begin
            words[i] = {$urandom, $urandom, $urandom, $urandom};
            if (high) words[i][DATA_W-1] = 1'b1;
        end
    endtask

    task automatic do_start(input bit m, input int r);
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.rounds = 8'(r);
        tick();
        bus.start  = 1'b0;
    endtask

    // Sends words[first..last] MS beat first; returns the cycle the first beat was presented.
    task automatic send_words(input int first, input int last, input bit gappy, input bit poke,
                              output int p0);
        p0 = cyc;
        for (int w = first; w <= last; w++) begin
            for (int b = BEATS - 1; b >= 0; b--) begin
                bus.iot_in = words[w][b*IN_W +: IN_W];
                bus.in_en  = 1'b1;
                tick();
                if (gappy) begin
                    bus.in_en = 1'b0;
                    bus.iot_in = IN_W'($urandom);
                    if (poke && w == 3 && b == BEATS - 1) begin
                        bus.start  = 1'b1;
                        bus.mode   = ~bus.mode;
                        bus.rounds = 8'd5;
                    end
                    tick();
                    bus.start = 1'b0;
                end
            end
        end
    endtask

    task automatic check_pulse(input string tag, input int k, input logic [DATA_W-1:0] ev,
                               input int eix, input int ecyc, input bit ebusy);
        logic [DATA_W-1:0] gv;
        gv = (q_val.size() > k) ? q_val[k] : '1;
        chk({tag, "_value"}, gv, ev);
        chk({tag, "_cycle"}, DATA_W'((q_cyc.size() > k) ? q_cyc[k] : -1), DATA_W'(ecyc));
        chk({tag, "_busy"}, DATA_W'((q_busy.size() > k) ? q_busy[k] : 1'bx), DATA_W'(ebusy));
`ifdef IOTF_INDEX_EN
        chk({tag, "_idx"}, DATA_W'((q_idx.size() > k) ? q_idx[k] : -1), DATA_W'(eix));
`else
        if (eix < 0) chk({tag, "_idx"}, DATA_W'(eix), DATA_W'(0));
`endif
    endtask

    task automatic one_round(input string tag, input bit m, input bit gappy, input bit poke);
        logic [DATA_W-1:0] ev;
        int eix, p0, lat;
        clear_q();
        ref_model(m, ev, eix);
        do_start(m, 1);
        send_words(0, ROUND_N - 1, gappy, poke, p0);
        bus.in_en = 1'b0;
        repeat (4) tick();
        lat = gappy ? 2 * BEATS * ROUND_N - 1 : BEATS * ROUND_N;
        chk({tag, "_npulse"}, DATA_W'(q_val.size()), DATA_W'(1));
        check_pulse(tag, 0, ev, eix, p0 + lat, 1'b0);
        chk({tag, "_busy_after"}, DATA_W'(bus.busy), DATA_W'(0));
    endtask

    initial begin
        logic [DATA_W-1:0] e1, e2;
        int i1, i2, p0, p1;
        bus.start = 1'b0; bus.mode = 1'b0; bus.rounds = 8'd0;
        bus.in_en = 1'b0; bus.iot_in = '0;
        repeat (3) tick();
        chk("reset_busy", DATA_W'(bus.busy), DATA_W'(0));
        chk("reset_valid", DATA_W'(bus.valid), DATA_W'(0));
        chk("reset_out", bus.iot_out, '0);
        rst = 1'b0;
        tick();

        // Beats presented while idle must be dropped.
        bus.in_en = 1'b1; bus.iot_in = 8'hA5;
        repeat (5) tick();
        bus.in_en = 1'b0;
        chk("idle_busy", DATA_W'(bus.busy), DATA_W'(0));

        load8(8, 5, 9, 5, 7, 3, 4, 6);
        one_round("min", 1'b0, 1'b0, 1'b0);
        one_round("max", 1'b1, 1'b0, 1'b0);
        load8(4, 2, 2, 7, 2, 9, 9, 9);
        one_round("tie", 1'b0, 1'b0, 1'b0);

        // Two back-to-back rounds; round 2 values all exceed round 1's minimum.
        clear_q();
        load8(8, 5, 9, 5, 7, 3, 4, 6);
        ref_model(1'b0, e1, i1);
        do_start(1'b0, 2);
        send_words(0, ROUND_N - 1, 1'b0, 1'b0, p0);
        load_rand(1'b1);
        ref_model(1'b0, e2, i2);
        send_words(0, ROUND_N - 1, 1'b0, 1'b0, p1);
        bus.in_en = 1'b0;
        repeat (4) tick();
        chk("two_npulse", DATA_W'(q_val.size()), DATA_W'(2));
        check_pulse("two_r1", 0, e1, i1, p0 + BEATS * ROUND_N, 1'b1);
        check_pulse("two_r2", 1, e2, i2, p0 + 2 * BEATS * ROUND_N, 1'b0);

        // Gapped beats with a mid-round start that tries to flip mode.
        load8(8, 5, 9, 5, 7, 3, 4, 6);
        one_round("gap_min", 1'b0, 1'b1, 1'b1);
        load_rand(1'b0);
        one_round("gap_max", 1'b1, 1'b1, 1'b1);

        // Reset mid-round aborts; a fresh round then completes normally.
        clear_q();
        load_rand(1'b0);
        do_start(1'b1, 1);
        send_words(0, 3, 1'b0, 1'b0, p0);
        bus.in_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_busy", DATA_W'(bus.busy), DATA_W'(0));
        chk("abort_out", bus.iot_out, '0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("abort_nopulse", DATA_W'(q_val.size()), DATA_W'(0));
        load_rand(1'b0);
        ref_model(1'b0, e1, i1);
        do_start(1'b0, 1);
        send_words(0, ROUND_N - 2, 1'b0, 1'b0, p0);
        chk("abort_out_hold", bus.iot_out, '0);
        send_words(ROUND_N - 1, ROUND_N - 1, 1'b0, 1'b0, p1);
        bus.in_en = 1'b0;
        repeat (4) tick();
        chk("restart_npulse", DATA_W'(q_val.size()), DATA_W'(1));
        check_pulse("restart", 0, e1, i1, p0 + BEATS * ROUND_N, 1'b0);

        // rounds = 0 never leaves idle.
        clear_q();
        do_start(1'b0, 0);
        bus.in_en = 1'b1;
        repeat (BEATS * ROUND_N + 4) tick();
        bus.in_en = 1'b0;
        chk("zero_busy", DATA_W'(bus.busy), DATA_W'(0));
        chk("zero_nopulse", DATA_W'(q_val.size()), DATA_W'(0));

        for (int k = 0; k < 4; k++) begin
            load_rand(1'b0);
            if (k == 2) begin
                words[6] = words[1];
                words[3] = words[1];
            end
            one_round($sformatf("rand%0d", k), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
